// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter with an 8-deep show-ahead byte FIFO and its own baud counter.
// Bytes are sent LSB-first; queued bytes follow each other with no idle gap between frames.
module uart_tx_fifo #(
  parameter int BPS_DIV = 434,
  parameter int FIFO_AW = 3
) (
  input  logic               sclk,
  input  logic               rst_n,
  input  logic [7:0]         tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic               tx,
  output logic               tx_busy,
  output logic [FIFO_AW:0]   fifo_cnt
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int BW    = $clog2(BPS_DIV);

  localparam logic [BW-1:0]      BAUD_ZERO = BW'(0);
  localparam logic [BW-1:0]      BAUD_ONE  = BW'(1);
  localparam logic [BW-1:0]      BAUD_LAST = BW'(BPS_DIV - 1);
  localparam logic [FIFO_AW:0]   CNT_ZERO  = (FIFO_AW + 1)'(0);
  localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]   CNT_FULL  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW-1:0] PTR_ZERO  = FIFO_AW'(0);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t             state_r;
  logic [BW-1:0]      baud_cnt_r;
  logic [2:0]         bit_cnt_r;
  logic [7:0]         shift_r;
  logic               tx_r;
  logic               busy_r;
  logic [FIFO_AW-1:0] wr_ptr_r;
  logic [FIFO_AW-1:0] rd_ptr_r;
  logic [FIFO_AW:0]   cnt_r;
  logic               avail_r;
  logic [7:0]         mem_r [DEPTH];

  logic               push_s;
  logic               pop_s;
  logic               bit_end_s;
  logic               full_s;
  logic [7:0]         head_s;

  // Handshake, bit timing and load decision
  always_comb begin
    full_s    = (cnt_r == CNT_FULL);
    push_s    = tx_valid && !full_s;
    bit_end_s = (baud_cnt_r == BAUD_LAST);
    head_s    = mem_r[rd_ptr_r];
    pop_s     = 1'b0;
    case (state_r)
      // an idle FSM only sees a fresh push one cycle after the count rises
      S_IDLE: begin
        if (avail_r && (cnt_r != CNT_ZERO)) begin
          pop_s = 1'b1;
        end else begin
          pop_s = 1'b0;
        end
      end
      S_STOP: begin
        if (bit_end_s && (cnt_r != CNT_ZERO)) begin
          pop_s = 1'b1;
        end else begin
          pop_s = 1'b0;
        end
      end
      default: pop_s = 1'b0;
    endcase
  end

  assign tx_ready = !full_s;
  assign tx       = tx_r;
  assign tx_busy  = busy_r;
  assign fifo_cnt = cnt_r;

  // FIFO storage write port
  always_ff @(posedge sclk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= tx_data;
    end
  end

  // FIFO pointers, occupancy and the delayed not-empty flag
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      cnt_r    <= CNT_ZERO;
      avail_r  <= 1'b0;
    end else begin
      avail_r <= (cnt_r != CNT_ZERO);
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (push_s && !pop_s) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else if (pop_s && !push_s) begin
        cnt_r <= cnt_r - CNT_ONE;
      end
    end
  end

  // Serialiser FSM with baud and bit counters
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      baud_cnt_r <= BAUD_ZERO;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'h00;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          baud_cnt_r <= BAUD_ZERO;
          if (pop_s) begin
            state_r <= S_START;
            shift_r <= head_s;
            tx_r    <= 1'b0;
            busy_r  <= 1'b1;
          end else begin
            tx_r   <= 1'b1;
            busy_r <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end_s) begin
            state_r    <= S_DATA;
            baud_cnt_r <= BAUD_ZERO;
            bit_cnt_r  <= 3'd0;
            tx_r       <= shift_r[0];
          end else begin
            baud_cnt_r <= baud_cnt_r + BAUD_ONE;
          end
        end
        S_DATA: begin
          if (bit_end_s) begin
            baud_cnt_r <= BAUD_ZERO;
            if (bit_cnt_r == 3'd7) begin
              state_r <= S_STOP;
              tx_r    <= 1'b1;
            end else begin
              shift_r   <= {1'b0, shift_r[7:1]};
              tx_r      <= shift_r[1];
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + BAUD_ONE;
          end
        end
        S_STOP: begin
          if (bit_end_s) begin
            baud_cnt_r <= BAUD_ZERO;
            // zero-gap framing: the next start bit follows the stop bit directly
            if (pop_s) begin
              state_r <= S_START;
              shift_r <= head_s;
              tx_r    <= 1'b0;
            end else begin
              state_r <= S_IDLE;
              tx_r    <= 1'b1;
              busy_r  <= 1'b0;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + BAUD_ONE;
          end
        end
        default: begin
          state_r    <= S_IDLE;
          baud_cnt_r <= BAUD_ZERO;
          tx_r       <= 1'b1;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a mid-bit sampling receiver model decodes every
// frame and compares it with a scoreboard of accepted bytes; instances at BPS_DIV=4 and 434.
module tb_uart_tx_fifo;

  logic       sclk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       sel;
  int         cur_div;

  logic       v4, v434;
  logic       rdy_a, tx_a, busy_a;
  logic       rdy_b, tx_b, busy_b;
  logic [3:0] cnt_a, cnt_b;
  logic       tx_mon, rdy_mon, busy_mon;
  logic [3:0] cnt_mon;

  always #5 sclk = ~sclk;

  assign v4       = tx_valid && !sel;
  assign v434     = tx_valid && sel;
  assign tx_mon   = sel ? tx_b   : tx_a;
  assign rdy_mon  = sel ? rdy_b  : rdy_a;
  assign busy_mon = sel ? busy_b : busy_a;
  assign cnt_mon  = sel ? cnt_b  : cnt_a;

  uart_tx_fifo #(.BPS_DIV(4)) dut4 (
    .sclk(sclk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(v4),
    .tx_ready(rdy_a), .tx(tx_a), .tx_busy(busy_a), .fifo_cnt(cnt_a)
  );

  uart_tx_fifo dut434 (
    .sclk(sclk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(v434),
    .tx_ready(rdy_b), .tx(tx_b), .tx_busy(busy_b), .fifo_cnt(cnt_b)
  );

  logic [7:0] sb[$];
  int         starts[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  bit         rx_on;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Receiver model: captures a whole frame, decodes mid-bit and checks every bit is exactly cur_div long
  initial begin : rx_model
    logic       fb [4340];
    int         t;
    bit         in_frame;
    logic [7:0] b;
    logic       m;
    bit         shape_ok;
    in_frame = 1'b0;
    t = 0;
    forever begin
      @(negedge sclk);
      cyc++;
      if (!rx_on) begin
        in_frame = 1'b0;
      end else if (!in_frame) begin
        if (tx_mon === 1'b0) begin
          in_frame = 1'b1;
          fb[0] = 1'b0;
          t = 1;
          starts.push_back(cyc);
        end
      end else begin
        fb[t] = tx_mon;
        t++;
        if (t == 10 * cur_div) begin
          in_frame = 1'b0;
          shape_ok = 1'b1;
          b = 8'h00;
          for (int k = 0; k < 10; k++) begin
            m = fb[k * cur_div + cur_div / 2];
            for (int j = 0; j < cur_div; j++)
              if (fb[k * cur_div + j] !== m) shape_ok = 1'b0;
            if (k >= 1 && k <= 8) b[k-1] = m;
          end
          if (fb[cur_div / 2] !== 1'b0) shape_ok = 1'b0;
          if (fb[9 * cur_div + cur_div / 2] !== 1'b1) shape_ok = 1'b0;
          check("frame_shape", {31'd0, shape_ok}, 32'd1);
          if (sb.size() == 0) begin
            check("frame_unexpected", {24'd0, b}, 32'hFFFF_FFFF);
          end else begin
            check("frame_byte", {24'd0, b}, {24'd0, sb.pop_front()});
          end
        end
      end
    end
  end

  // Presents d and holds tx_valid until accepted; returns at the negedge after the accepting edge
  task automatic send(input logic [7:0] d, output int waited);
    tx_data  = d;
    tx_valid = 1'b1;
    waited   = 0;
    while (!rdy_mon && waited < 200) begin
      @(negedge sclk);
      waited++;
    end
    if (!rdy_mon) begin
      check("send_timeout", {31'd0, rdy_mon}, 32'd1);
    end else begin
      sb.push_back(d);
      @(posedge sclk);
      @(negedge sclk);
    end
  endtask

  task automatic wait_drain(input int lim);
    int w;
    w = 0;
    while ((sb.size() != 0 || busy_mon || cnt_mon != 4'd0) && w < lim) begin
      @(negedge sclk);
      w++;
    end
    check("drain", {31'd0, (sb.size() == 0 && !busy_mon)}, 32'd1);
    repeat (3) @(negedge sclk);
  endtask

  typedef struct {
    int         n;
    logic [7:0] base;
    logic [7:0] step;
    logic [3:0] exp_cnt;
    logic       exp_ready;
    logic       exp_busy;
  } vec_t;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs[5];
    int   w, bc;
    bit   ok;

    vecs[0] = '{1, 8'h11, 8'h01, 4'd1, 1'b1, 1'b0};
    vecs[1] = '{2, 8'h80, 8'h01, 4'd2, 1'b1, 1'b0};
    vecs[2] = '{3, 8'hC3, 8'h11, 4'd2, 1'b1, 1'b1};
    vecs[3] = '{6, 8'h10, 8'h07, 4'd5, 1'b1, 1'b1};
    vecs[4] = '{9, 8'hF0, 8'h01, 4'd8, 1'b0, 1'b1};

    rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    sel = 1'b0; cur_div = 4; rx_on = 1'b1;
    repeat (3) @(negedge sclk);
    check("rst_tx",    {31'd0, tx_a},   32'd1);
    check("rst_busy",  {31'd0, busy_a}, 32'd0);
    check("rst_cnt",   {28'd0, cnt_a},  32'd0);
    check("rst_ready", {31'd0, rdy_a},  32'd1);
    check("rst_tx434", {31'd0, tx_b},   32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge sclk);

    // single byte: latency, frame shape and busy length
    send(8'hA5, w);
    tx_valid = 1'b0;
    tx_data  = 8'h5A;
    check("a5_cnt_n0",  {28'd0, cnt_mon},  32'd1);
    check("a5_busy_n0", {31'd0, busy_mon}, 32'd0);
    @(negedge sclk);
    check("a5_tx_n1",   {31'd0, tx_mon},   32'd1);
    @(negedge sclk);
    check("a5_tx_n2",   {31'd0, tx_mon},   32'd0);
    check("a5_cnt_n2",  {28'd0, cnt_mon},  32'd0);
    bc = 0;
    while (busy_mon && bc < 100) begin
      bc++;
      @(negedge sclk);
    end
    check("a5_busy_len", bc, 32'd40);
    wait_drain(100);

    // table: fill levels after n consecutive pushes from idle
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < vecs[i].n; j++)
        send(8'(vecs[i].base + j * vecs[i].step), w);
      tx_valid = 1'b0;
      check("vec_cnt",   {28'd0, cnt_mon},  {28'd0, vecs[i].exp_cnt});
      check("vec_ready", {31'd0, rdy_mon},  {31'd0, vecs[i].exp_ready});
      check("vec_busy",  {31'd0, busy_mon}, {31'd0, vecs[i].exp_busy});
      wait_drain(600);
    end

    // back-to-back frames start exactly 40 cycles apart
    starts.delete();
    send(8'h00, w);
    send(8'hFF, w);
    send(8'h55, w);
    tx_valid = 1'b0;
    wait_drain(400);
    check("b2b_frames", starts.size(), 32'd3);
    if (starts.size() == 3) begin
      check("b2b_gap1", starts[1] - starts[0], 32'd40);
      check("b2b_gap2", starts[2] - starts[1], 32'd40);
    end

    // full FIFO: 0x0A held off until the first pop
    for (int d = 1; d <= 9; d++) send(8'(d), w);
    check("full_cnt",   {28'd0, cnt_mon}, 32'd8);
    check("full_ready", {31'd0, rdy_mon}, 32'd0);
    send(8'h0A, w);
    tx_valid = 1'b0;
    check("full_holdoff", w, 32'd34);
    check("full_cnt_after", {28'd0, cnt_mon}, 32'd8);
    wait_drain(800);

    // simultaneous push and pop at the STOP->START edge
    send(8'h96, w);
    tx_valid = 1'b0;
    repeat (9) @(negedge sclk);
    send(8'h3A, w);
    tx_valid = 1'b0;
    repeat (31) @(negedge sclk);
    check("sim_cnt_pre", {28'd0, cnt_mon}, 32'd1);
    send(8'hE7, w);
    tx_valid = 1'b0;
    check("sim_cnt_post", {28'd0, cnt_mon}, 32'd1);
    check("sim_tx_start", {31'd0, tx_mon},  32'd0);
    check("sim_busy",     {31'd0, busy_mon}, 32'd1);
    wait_drain(200);

    // reset during DATA bit 3 with 4 bytes queued
    rx_on = 1'b0;
    for (int d = 0; d < 5; d++) send(8'(d), w);
    tx_valid = 1'b0;
    repeat (15) @(negedge sclk);
    check("rst_pre_tx",  {31'd0, tx_mon},  32'd0);
    check("rst_pre_cnt", {28'd0, cnt_mon}, 32'd4);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx",    {31'd0, tx_mon},   32'd1);
    check("rst_mid_cnt",   {28'd0, cnt_mon},  32'd0);
    check("rst_mid_busy",  {31'd0, busy_mon}, 32'd0);
    check("rst_mid_ready", {31'd0, rdy_mon},  32'd1);
    sb.delete();
    @(negedge sclk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (50) begin
      @(negedge sclk);
      if (tx_mon !== 1'b1 || busy_mon !== 1'b0) ok = 1'b0;
    end
    check("rst_quiet", {31'd0, ok}, 32'd1);
    rx_on = 1'b1;
    send(8'h6B, w);
    tx_valid = 1'b0;
    wait_drain(100);

    // default divider: 434 cycles per bit
    sel = 1'b1;
    cur_div = 434;
    repeat (2) @(negedge sclk);
    send(8'h3C, w);
    tx_valid = 1'b0;
    repeat (2) @(negedge sclk);
    bc = 0;
    while (busy_mon && bc < 5000) begin
      bc++;
      @(negedge sclk);
    end
    check("d434_busy_len", bc, 32'd4340);
    wait_drain(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- 8N1 UART transmitter, the send side of the serial link.
- Owns its own baud counter and an 8-deep byte FIFO.
- Upstream logic (e.g. the image/result path) pushes bytes with a valid/ready handshake.
- The block serialises bytes LSB-first onto tx, back-to-back with no idle gap while the FIFO holds data.

Parameters:
- BPS_DIV, 434, sclk cycles per serial bit (115200 baud at 50 MHz); legal range 2..8191.
- FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW = 8 entries.

Ports:
- sclk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_data  input  8  byte to send; sampled when tx_valid&&tx_ready.
- tx_valid  input  1  upstream byte valid.
- tx_ready  output  1  FIFO not full; combinational from the registered count.
- tx  output  1  serial line, registered; idle high.
- tx_busy  output  1  FSM not in IDLE.
- fifo_cnt  output  FIFO_AW+1  bytes currently queued, range 0..8.

Behaviour:
- Reset values (async, immediate): tx=1, tx_busy=0, fifo_cnt=0, tx_ready=1, FSM=IDLE, baud_cnt=0, bit_cnt=0, FIFO pointers=0.
- Push: on an edge with tx_valid=1 and tx_ready=1, write tx_data at wr_ptr, wr_ptr+1 (wraps modulo 8).
- tx_valid while full is ignored; no data is lost from the queue and no error flag is raised.
- Pop: FIFO is show-ahead (head byte readable combinationally). On a pop, rd_ptr+1 (wraps).
- A pop happens only when the FSM loads a byte.
- fifo_cnt: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Push and pop may coincide when 1<=fifo_cnt<=7.
- When full, tx_ready=0, so a pop in that cycle raises tx_ready on the next cycle.
- Push into an empty FIFO is not visible to the FSM until the following cycle.
- Baud counter: baud_cnt runs 0..BPS_DIV-1 while FSM!=IDLE and is held at 0 in IDLE.
- bit_end = (baud_cnt==BPS_DIV-1). Each bit lasts exactly BPS_DIV cycles.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: tx=1. If fifo_cnt!=0, go to START at the next edge: tx<=0, shift_reg<=head byte, pop, baud_cnt<=0.
- START: on bit_end go to DATA, tx<=shift_reg[0], bit_cnt<=0.
- DATA: on bit_end, if bit_cnt==7 go to STOP with tx<=1. Otherwise shift_reg>>1, tx<=next bit, bit_cnt+1.
- STOP: on bit_end, if fifo_cnt!=0 go directly to START with the same loading actions as from IDLE (zero-gap framing). Otherwise go to IDLE.
- Timing: frame length is exactly 10*BPS_DIV cycles, and consecutive queued bytes start exactly 10*BPS_DIV cycles apart.
- Latency: a byte accepted at edge N into an empty FIFO with the FSM in IDLE sees tx fall at edge N+2. The push is visible at N+1 and the FSM moves to START at edge N+2.
- tx_busy=1 from the START entry edge through the last STOP cycle. It drops at the edge returning to IDLE.
- Reset mid-frame: tx returns high immediately, the queue is discarded, and the truncated frame is not resumed.
- tx_data is not re-sampled after the push; later changes to tx_data do not affect queued bytes.

Test Plan:
- Single byte, BPS_DIV=4: push 0xA5 at edge N -> tx low at N+2 for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then stop high 4 cycles; tx_busy high 40 cycles; fifo_cnt 1->0.
- Back-to-back, BPS_DIV=4: push 0x00,0xFF,0x55 consecutively -> three frames with no high gap between stop and next start; each start bit begins 40 cycles after the previous; decoded bytes match in order.
- Full FIFO: with FSM busy, push 9 bytes 0x01..0x09 while holding tx_valid -> tx_ready=0 once fifo_cnt=8 (0x01 already loaded, so 0x02..0x09 queued). 0x0A is held off until the first pop, then accepted. The output sequence is 0x01..0x0A with no loss or duplication.
- Simultaneous push/pop: fifo_cnt=1 and a push in the same cycle the FSM loads from STOP -> fifo_cnt stays 1, correct byte order.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 with 4 bytes queued -> tx=1 and fifo_cnt=0 immediately. After release, tx stays high and tx_busy=0 until a new push.
- Default BPS_DIV=434: push 0x3C -> each bit exactly 434 cycles, frame 4340 cycles, verified by a bench UART receiver model sampling mid-bit.
